// File: rtl/mat_calc_pkg.sv
// Shared types and constants for the error countdown supervisor.
package mat_calc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCount   = 2'd1,
    StExpired = 2'd2,
    StLocked  = 2'd3
  } sup_state_t;

  localparam int unsigned CLK_FREQ = 100_000_000;

  localparam logic SEG_MODE_OP  = 1'b0;
  localparam logic SEG_MODE_CNT = 1'b1;

  // Index of the lowest set bit; bit 0 is the highest-priority source.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/err_countdown_supervisor_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CntMax);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CntMax) ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/err_countdown_supervisor.sv
// Error supervisor: edge-detects error sources, runs a programmable seconds countdown
// and drives the seg7 enable/mode/digit plus a timeout pulse for the control FSM.
module err_countdown_supervisor
  import mat_calc_pkg::*;
#(
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned TICK_DIV    = CLK_FREQ,
  parameter int unsigned SEC_W       = 4,
  parameter int unsigned DEFAULT_SEC = 10,
  parameter int unsigned RETRIGGER   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_err,
  input  logic             i_lock,
  input  logic             i_calc_busy,
  input  logic             i_clear,
  input  logic [SEC_W-1:0] i_cfg_sec,
  output logic             o_timeout,
  output logic [SEC_W-1:0] o_time_val,
  output logic             o_seg_en,
  output logic             o_seg_mode,
  output logic [2:0]       o_err_src,
  output logic             o_active
);

  sup_state_t       r_state;
  logic [N_SRC-1:0] r_err_d;
  logic [SEC_W-1:0] r_sec;
  logic             r_timeout;
  logic             r_seg_en;
  logic             r_seg_mode;
  logic [2:0]       r_err_src;
  logic             r_active;

  logic [N_SRC-1:0] w_rise;
  logic [7:0]       w_rise8;
  logic [2:0]       w_src;
  logic [SEC_W-1:0] w_load_sec;
  logic             w_load;
  logic             w_tick;

  assign w_rise = i_err & ~r_err_d;

  always_comb begin
    w_rise8 = '0;
    w_rise8[N_SRC-1:0] = w_rise;
  end

  assign w_src      = lowest_set(w_rise8);
  assign w_load_sec = (i_cfg_sec == '0) ? SEC_W'(DEFAULT_SEC) : i_cfg_sec;
  // A load also restarts the prescaler so the first tick lands TICK_DIV cycles later.
  assign w_load     = !i_lock && !i_clear && (|w_rise) &&
                      ((r_state == StIdle) || ((r_state == StCount) && (RETRIGGER != 0)));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == StCount),
    .i_clr (w_load),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_err_d    <= '0;
      r_sec      <= '0;
      r_timeout  <= 1'b0;
      r_seg_en   <= 1'b0;
      r_seg_mode <= SEG_MODE_OP;
      r_err_src  <= '0;
      r_active   <= 1'b0;
    end else begin
      r_err_d    <= i_err;
      r_timeout  <= 1'b0;
      r_seg_en   <= i_calc_busy;
      r_seg_mode <= SEG_MODE_OP;
      r_active   <= 1'b0;
      if (i_lock) begin
        r_state  <= StLocked;
        r_seg_en <= 1'b0;
      end else if (i_clear) begin
        r_state <= StIdle;
        r_sec   <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_load) begin
              r_state    <= StCount;
              r_sec      <= w_load_sec;
              r_err_src  <= w_src;
              r_seg_en   <= 1'b1;
              r_seg_mode <= SEG_MODE_CNT;
              r_active   <= 1'b1;
            end
          end
          StCount: begin
            r_seg_en   <= 1'b1;
            r_seg_mode <= SEG_MODE_CNT;
            r_active   <= 1'b1;
            if (i_err == '0) begin
              r_state    <= StIdle;
              r_sec      <= '0;
              r_seg_en   <= i_calc_busy;
              r_seg_mode <= SEG_MODE_OP;
              r_active   <= 1'b0;
            end else if (w_load) begin
              r_sec     <= w_load_sec;
              r_err_src <= w_src;
            end else if (w_tick) begin
              if (r_sec > SEC_W'(1)) begin
                r_sec <= r_sec - SEC_W'(1);
              end else begin
                r_sec     <= '0;
                r_timeout <= 1'b1;
                r_state   <= StExpired;
                r_active  <= 1'b0;
              end
            end
          end
          StExpired: begin
            if (i_err == '0) begin
              r_state <= StIdle;
            end else begin
              r_seg_en   <= 1'b1;
              r_seg_mode <= SEG_MODE_CNT;
            end
          end
          StLocked: r_state <= StIdle;
          default:  r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_timeout  = r_timeout;
  assign o_time_val = r_sec;
  assign o_seg_en   = r_seg_en;
  assign o_seg_mode = r_seg_mode;
  assign o_err_src  = r_err_src;
  assign o_active   = r_active;

endmodule
